id_hazard_scoreboard: RTL and testbench
=======================================

# id_hazard_scoreboard

Register scoreboard and stall controller for the instruction-decode stage. Tracks in-flight writes per GPR, compares them with the source/destination registers of the instruction currently in ID, and decides each cycle whether that instruction issues into ID/EX or holds IF/ID and sends a bubble. It sits beside the decode datapath and drives the PC/IF_ID write-enable and the ID_EX NOP-insert control.

## Interface
- NREGS, 32: number of architectural registers; register 0 is hardwired zero.
- CNTW, 2: width of the per-register in-flight counter; max in-flight writers per register = 2^CNTW-1.
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_id_valid  in  1  valid instruction present in ID
- i_rs, i_rt  in  5 each  source register selects of ID instruction
- i_rs_used, i_rt_used  in  1 each  source actually read
- i_dst  in  5  destination register of ID instruction (rd, rt or link reg 31, already muxed)
- i_dst_wr  in  1  ID instruction writes i_dst
- i_is_load  in  1  ID instruction is a memory load
- i_flush  in  1  squash ID instruction this cycle (branch/jump taken)
- i_wb_valid  in  1  a previously issued dst-writing instruction retires this cycle
- i_wb_rd  in  5  its destination register
- o_issue  out  1  ID instruction advances to ID/EX this cycle
- o_stall  out  1  hold PC and IF_ID register
- o_bubble  out  1  load NOP into ID_EX
- o_err  out  1  sticky: retire seen for register with zero count
- o_stall_cycles  out  32  saturating count of stalled cycles

## Operation
- State: cnt[r] (CNTW bits) for r=1..NREGS-1; cnt[0] constant 0; o_err; o_stall_cycles; with forwarding, ld_rd/ld_vld (pending-load tracker).
- busy(r) = cnt[r]!=0 (without forwarding).
- Hazard = i_id_valid & ((i_rs_used & busy(i_rs)) | (i_rt_used & busy(i_rt)) | (i_dst_wr & cnt[i_dst]==max)).
- o_stall = hazard & !i_flush; o_bubble = o_stall | i_flush; o_issue = i_id_valid & !hazard & !i_flush.
- Issue with i_dst_wr & i_dst!=0: cnt[i_dst]+1. Retire with i_wb_rd!=0: cnt[i_wb_rd]-1. Both on same reg same cycle: unchanged.
- Retire on cnt==0: no change, set o_err. Register 0: never counted, never busy.
- Same-cycle retire of register X clears busy(X) only from next cycle (regfile write not bypassed into read).
- i_flush overrides hazard: instruction dropped, no counter update, no stall.
- o_stall_cycles increments when o_stall=1, saturates at 0xFFFFFFFF.

## Timing
- Outputs o_stall/o_bubble/o_issue combinational from registered state and current-cycle ID inputs; no added latency.
- Counter/tracker updates visible next rising edge.
- Reset: all cnt=0, ld_vld=0, o_err=0, o_stall_cycles=0; with i_id_valid=0 all of o_issue/o_stall/o_bubble=0.
- Reset asserted mid-stall: state cleared immediately (async); stall drops in same cycle.
- Back-to-back dependent ALU ops without forwarding: 3 stall cycles (EX, MEM, WB retire, then read).

## Configuration
- FORWARDING_EN defined: counters not used for ALU results; busy(r) = ld_vld & ld_rd==r. Issue of i_is_load & i_dst_wr sets ld_rd=i_dst, ld_vld=1; ld_vld clears next cycle unless another load issues. Load-use distance 1 gives exactly 1 stall; i_wb_* ignored for hazard, o_err tied 0.
- Not defined: full scoreboard behaviour above.

## Structure
- Shared pipeline package: NREGS, REG_ZERO=0, REG_LINK=31, register-select width 5.
- Sub-module reg_inflight_counter (one CNTW-bit up/down counter with simultaneous inc/dec, underflow flag), generated per register.

## Test plan
- Reset, then issue add r3 writing 3 followed by sub reading r3 -> sub stalls 3 cycles, issues in cycle retire(r3)+1; o_stall_cycles=3.
- Two writers to r5 issued, one retire -> cnt[5]=1, reader still stalled; second retire -> reader issues next cycle.
- Issue and retire of r7 same cycle -> cnt[7] unchanged; i_dst=0 issue -> no count, r0 reader never stalls.
- Hazard with i_flush=1 -> o_stall=0, o_bubble=1, o_issue=0, no counter change.
- Retire r9 with cnt[9]=0 -> o_err=1 and stays 1 until reset; reset mid-stall -> o_stall=0 immediately.
- FORWARDING_EN: lw r4 then add reading r4 -> exactly 1 stall; add r4 then add reading r4 -> 0 stalls.

Source files
------------

// File: rtl/id_hazard_scoreboard_pkg.sv
// rtl/id_hazard_scoreboard_pkg.sv - shared pipeline constants and types for the ID hazard scoreboard
package id_hazard_scoreboard_pkg;

    // Architectural register file geometry
    localparam int NREGS  = 32;
    localparam int RSEL_W = 5;

    // Width of each per-register in-flight writer counter
    localparam int CNTW = 2;

    typedef logic [RSEL_W-1:0] rsel_t;
    typedef logic [CNTW-1:0]   cnt_t;

    localparam rsel_t REG_ZERO = 5'd0;
    localparam rsel_t REG_LINK = 5'd31;

    // Largest number of writers that may be outstanding on one register
    function automatic cnt_t cnt_max();
        return {CNTW{1'b1}};
    endfunction

endpackage

// File: rtl/id_hazard_scoreboard_if.sv
// rtl/id_hazard_scoreboard_if.sv - decode-stage hazard interface between ID datapath and scoreboard
interface id_hazard_scoreboard_if;
    import id_hazard_scoreboard_pkg::*;

    // Instruction currently in ID
    logic        i_id_valid;
    rsel_t       i_rs;
    rsel_t       i_rt;
    logic        i_rs_used;
    logic        i_rt_used;
    rsel_t       i_dst;
    logic        i_dst_wr;
    logic        i_is_load;
    logic        i_flush;

    // Retirement (writeback) of a previously issued writer
    logic        i_wb_valid;
    rsel_t       i_wb_rd;

    // Pipeline control back to IF/ID and ID/EX
    logic        o_issue;
    logic        o_stall;
    logic        o_bubble;
    logic        o_err;
    logic [31:0] o_stall_cycles;

    modport master (
        output i_id_valid, i_rs, i_rt, i_rs_used, i_rt_used,
        output i_dst, i_dst_wr, i_is_load, i_flush,
        output i_wb_valid, i_wb_rd,
        input  o_issue, o_stall, o_bubble, o_err, o_stall_cycles
    );

    modport slave (
        input  i_id_valid, i_rs, i_rt, i_rs_used, i_rt_used,
        input  i_dst, i_dst_wr, i_is_load, i_flush,
        input  i_wb_valid, i_wb_rd,
        output o_issue, o_stall, o_bubble, o_err, o_stall_cycles
    );

endinterface

// File: rtl/id_hazard_scoreboard_reg_inflight_counter.sv
// rtl/id_hazard_scoreboard_reg_inflight_counter.sv - per-register up/down count of in-flight writers
module reg_inflight_counter #(
    parameter int W = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_cnt,
    output logic         o_underflow
);

    logic [W-1:0] r_cnt;

    // A retire against an empty counter is a bookkeeping error upstream
    assign o_underflow = i_dec & (r_cnt == '0);
    assign o_cnt       = r_cnt;

    // Simultaneous issue and retire cancel; saturate at both ends so the count never wraps
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_inc && !i_dec && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end else if (i_dec && !i_inc && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

endmodule

// File: rtl/id_hazard_scoreboard.sv
// rtl/id_hazard_scoreboard.sv - ID-stage register scoreboard and stall control; optional FORWARDING_EN
module id_hazard_scoreboard
    import id_hazard_scoreboard_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    id_hazard_scoreboard_if.slave bus
);

    logic        w_busy_rs;
    logic        w_busy_rt;
    logic        w_dst_full;
    logic        w_hazard;
    logic        w_issue;
    logic        w_stall;
    logic [31:0] r_stall_cycles;

`ifndef FORWARDING_EN
    // Full scoreboard: every writer is tracked until it retires
    cnt_t             w_cnt [NREGS];
    logic [NREGS-1:0] w_uf;
    logic             r_err;
    logic             w_unused_ld;

    assign w_cnt[0]    = '0;
    assign w_uf[0]     = 1'b0;
    assign w_unused_ld = bus.i_is_load;

    for (genvar g = 1; g < NREGS; g++) begin : g_cnt
        logic w_inc;
        logic w_dec;

        assign w_inc = w_issue & bus.i_dst_wr & (bus.i_dst == RSEL_W'(g));
        assign w_dec = bus.i_wb_valid & (bus.i_wb_rd == RSEL_W'(g));

        reg_inflight_counter #(.W(CNTW)) u_cnt (
            .i_clk       (i_clk),
            .i_rst       (i_rst),
            .i_inc       (w_inc),
            .i_dec       (w_dec),
            .o_cnt       (w_cnt[g]),
            .o_underflow (w_uf[g])
        );
    end

    // Retire in the same cycle is not bypassed: busy is judged on the registered count
    assign w_busy_rs  = (w_cnt[bus.i_rs] != '0);
    assign w_busy_rt  = (w_cnt[bus.i_rt] != '0);
    assign w_dst_full = bus.i_dst_wr & (w_cnt[bus.i_dst] == cnt_max());

    // Sticky error once any retire hits an empty counter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_err <= 1'b0;
        end else if (|w_uf) begin
            r_err <= 1'b1;
        end
    end

    assign bus.o_err = r_err;
`else
    // With forwarding only a load result one slot ahead can block a reader
    logic  r_ld_vld;
    rsel_t r_ld_rd;
    logic  w_unused_wb;

    assign w_unused_wb = ^{bus.i_wb_valid, bus.i_wb_rd};
    assign w_busy_rs   = r_ld_vld & (r_ld_rd == bus.i_rs) & (bus.i_rs != REG_ZERO);
    assign w_busy_rt   = r_ld_vld & (r_ld_rd == bus.i_rt) & (bus.i_rt != REG_ZERO);
    assign w_dst_full  = 1'b0;

    // Remember an issuing load for exactly one cycle (its load-use window)
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ld_vld <= 1'b0;
            r_ld_rd  <= REG_ZERO;
        end else begin
            r_ld_vld <= w_issue & bus.i_is_load & bus.i_dst_wr & (bus.i_dst != REG_ZERO);
            r_ld_rd  <= bus.i_dst;
        end
    end

    assign bus.o_err = 1'b0;
`endif

    assign w_hazard = bus.i_id_valid &
                      ((bus.i_rs_used & w_busy_rs) |
                       (bus.i_rt_used & w_busy_rt) |
                       w_dst_full);

    // A flush drops the instruction outright, so it never stalls
    assign w_stall = w_hazard & ~bus.i_flush;
    assign w_issue = bus.i_id_valid & ~w_hazard & ~bus.i_flush;

    assign bus.o_stall  = w_stall;
    assign bus.o_bubble = w_stall | bus.i_flush;
    assign bus.o_issue  = w_issue;

    // Saturating count of cycles spent stalled
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign bus.o_stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// tb/tb_id_hazard_scoreboard.sv - self-checking bench for id_hazard_scoreboard
module tb_id_hazard_scoreboard;
    import id_hazard_scoreboard_pkg::*;

    typedef struct {
        int t;
        int rd;
    } ret_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_hazard_scoreboard_if bus();

    id_hazard_scoreboard dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int              n_vec = 0;
    int              n_bad = 0;
    int              m_cnt [NREGS];
    bit              m_err;
    longint unsigned m_stalls;

    task automatic set_id(input bit v, input int rs, input bit rsu, input int rt, input bit rtu,
                          input int dst, input bit dwr, input bit ld, input bit fl);
        bus.i_id_valid = v;
        bus.i_rs       = 5'(rs);
        bus.i_rs_used  = rsu;
        bus.i_rt       = 5'(rt);
        bus.i_rt_used  = rtu;
        bus.i_dst      = 5'(dst);
        bus.i_dst_wr   = dwr;
        bus.i_is_load  = ld;
        bus.i_flush    = fl;
    endtask

    task automatic set_wb(input bit v, input int rd);
        bus.i_wb_valid = v;
        bus.i_wb_rd    = 5'(rd);
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_wb(0, 0);
    endtask

    task automatic m_clear();
        for (int r = 0; r < NREGS; r++) m_cnt[r] = 0;
        m_err    = 0;
        m_stalls = 0;
    endtask

    // Reference hazard rule: a read of a register with writers outstanding, or a
    // write to a register whose writer budget is exhausted
    function automatic bit m_hazard();
        int maxw = (1 << CNTW) - 1;
        bit h    = 0;
        if (bus.i_rs_used && bus.i_rs != 0 && m_cnt[bus.i_rs] > 0) h = 1;
        if (bus.i_rt_used && bus.i_rt != 0 && m_cnt[bus.i_rt] > 0) h = 1;
        if (bus.i_dst_wr && bus.i_dst != 0 && m_cnt[bus.i_dst] >= maxw) h = 1;
        return bus.i_id_valid && h;
    endfunction

    // Advance the reference state by one clock edge using the inputs now driven
    task automatic m_commit();
        bit h   = m_hazard();
        bit iss = bus.i_id_valid && !h && !bus.i_flush;
        int d   = (iss && bus.i_dst_wr) ? int'(bus.i_dst) : 0;
        int w   = bus.i_wb_valid ? int'(bus.i_wb_rd) : 0;
        if (h && !bus.i_flush && m_stalls != 64'hFFFF_FFFF) m_stalls++;
        if (w != 0 && m_cnt[w] == 0) m_err = 1;
        if (!(d != 0 && d == w)) begin
            if (d != 0) m_cnt[d]++;
            if (w != 0 && m_cnt[w] > 0) m_cnt[w]--;
        end
    endtask

    task automatic tick();
        m_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        m_clear();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        m_clear();
        @(posedge clk);
        #2;
        n_vec++;
        if ({bus.o_issue, bus.o_stall, bus.o_bubble, bus.o_err} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_ctl got %b want 0000",
                     {bus.o_issue, bus.o_stall, bus.o_bubble, bus.o_err});
        end
        n_vec++;
        if (bus.o_stall_cycles !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_stallcnt got %0d want 0", bus.o_stall_cycles);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        set_id(1, 3, 1, 4, 1, 5, 1, 0, 0);
        #2;
        n_vec++;
        if ({bus.o_issue, bus.o_stall, bus.o_bubble} !== 3'b100) begin
            n_bad++;
            $display("FAIL reset_first_issue got %b want 100",
                     {bus.o_issue, bus.o_stall, bus.o_bubble});
        end
        idle();
    endtask

`ifndef FORWARDING_EN
    task automatic test_dependent();
        do_reset();
        set_id(1, 1, 1, 2, 1, 3, 1, 0, 0);
        #2;
        n_vec++;
        if (bus.o_issue !== 1'b1) begin
            n_bad++;
            $display("FAIL dep_add_issue got %b want 1", bus.o_issue);
        end
        tick();
        set_id(1, 3, 1, 4, 1, 6, 1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            if (k == 2) set_wb(1, 3); else set_wb(0, 0);
            #2;
            n_vec++;
            if ({bus.o_issue, bus.o_stall, bus.o_bubble} !== ((k < 3) ? 3'b011 : 3'b100)) begin
                n_bad++;
                $display("FAIL dep_sub k=%0d got %b want %b", k,
                         {bus.o_issue, bus.o_stall, bus.o_bubble}, (k < 3) ? 3'b011 : 3'b100);
            end
            tick();
        end
        idle();
        n_vec++;
        if (bus.o_stall_cycles !== 32'd3) begin
            n_bad++;
            $display("FAIL dep_stallcnt got %0d want 3", bus.o_stall_cycles);
        end
    endtask

    task automatic test_two_writers();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            if (c < 2) set_id(1, c + 1, 1, 0, 0, 5, 1, 0, 0);
            else       set_id(1, 5, 1, 0, 0, 0, 0, 0, 0);
            if (c == 3 || c == 4) set_wb(1, 5); else set_wb(0, 0);
            #2;
            n_vec++;
            if ({bus.o_issue, bus.o_stall} !== ((c < 2 || c == 5) ? 2'b10 : 2'b01)) begin
                n_bad++;
                $display("FAIL two_wr c=%0d got %b want %b", c, {bus.o_issue, bus.o_stall},
                         (c < 2 || c == 5) ? 2'b10 : 2'b01);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_counter_max();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            set_id(1, 0, 0, 0, 0, 5, 1, 0, 0);
            if (c == 3) set_wb(1, 5); else set_wb(0, 0);
            #2;
            n_vec++;
            if (bus.o_stall !== ((c == 3) ? 1'b1 : 1'b0)) begin
                n_bad++;
                $display("FAIL cnt_max c=%0d got %b want %b", c, bus.o_stall, c == 3);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_same_cycle();
        do_reset();
        set_id(1, 0, 0, 0, 0, 7, 1, 0, 0);
        tick();
        idle();
        tick();
        tick();
        set_id(1, 0, 0, 0, 0, 7, 1, 0, 0);
        set_wb(1, 7);
        #2;
        n_vec++;
        if (bus.o_issue !== 1'b1) begin
            n_bad++;
            $display("FAIL same_cyc_issue got %b want 1", bus.o_issue);
        end
        tick();
        set_wb(0, 0);
        set_id(1, 7, 1, 0, 0, 0, 0, 0, 0);
        #2;
        n_vec++;
        if (bus.o_stall !== 1'b1) begin
            n_bad++;
            $display("FAIL same_cyc_r7_busy got %b want 1", bus.o_stall);
        end
        for (int c = 0; c < 5; c++) begin
            set_id(1, 0, 1, 0, 1, 0, 1, 0, 0);
            #2;
            n_vec++;
            if ({bus.o_issue, bus.o_stall} !== 2'b10) begin
                n_bad++;
                $display("FAIL r0_never_busy c=%0d got %b want 10", c, {bus.o_issue, bus.o_stall});
            end
            tick();
        end
        set_id(1, 0, 0, 0, 0, int'(REG_LINK), 1, 0, 0);
        tick();
        set_id(1, 2, 1, int'(REG_LINK), 1, 0, 0, 0, 0);
        #2;
        n_vec++;
        if (bus.o_stall !== 1'b1) begin
            n_bad++;
            $display("FAIL link_busy got %b want 1", bus.o_stall);
        end
        idle();
    endtask

    task automatic test_flush();
        do_reset();
        set_id(1, 0, 0, 0, 0, 8, 1, 0, 0);
        tick();
        set_id(1, 8, 1, 0, 0, 9, 1, 0, 1);
        #2;
        n_vec++;
        if ({bus.o_issue, bus.o_stall, bus.o_bubble} !== 3'b001) begin
            n_bad++;
            $display("FAIL flush_ctl got %b want 001", {bus.o_issue, bus.o_stall, bus.o_bubble});
        end
        tick();
        set_id(1, 9, 1, 0, 0, 0, 0, 0, 0);
        #2;
        n_vec++;
        if ({bus.o_issue, bus.o_stall} !== 2'b10) begin
            n_bad++;
            $display("FAIL flush_no_count got %b want 10", {bus.o_issue, bus.o_stall});
        end
        n_vec++;
        if (bus.o_stall_cycles !== 32'd0) begin
            n_bad++;
            $display("FAIL flush_stallcnt got %0d want 0", bus.o_stall_cycles);
        end
        idle();
    endtask

    task automatic test_err_and_reset();
        do_reset();
        set_wb(1, 9);
        #2;
        n_vec++;
        if (bus.o_err !== 1'b0) begin
            n_bad++;
            $display("FAIL err_early got %b want 0", bus.o_err);
        end
        tick();
        set_wb(0, 0);
        for (int c = 0; c < 3; c++) begin
            #2;
            n_vec++;
            if (bus.o_err !== 1'b1) begin
                n_bad++;
                $display("FAIL err_sticky c=%0d got %b want 1", c, bus.o_err);
            end
            tick();
        end
        set_id(1, 0, 0, 0, 0, 10, 1, 0, 0);
        tick();
        set_id(1, 10, 1, 0, 0, 0, 0, 0, 0);
        #2;
        n_vec++;
        if (bus.o_stall !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_rst_stall got %b want 1", bus.o_stall);
        end
        rst = 1'b1;
        m_clear();
        #1;
        n_vec++;
        if ({bus.o_stall, bus.o_err, bus.o_issue} !== 3'b001 || bus.o_stall_cycles !== 32'd0) begin
            n_bad++;
            $display("FAIL async_rst stall/err/issue=%b cnt=%0d want 001 cnt=0",
                     {bus.o_stall, bus.o_err, bus.o_issue}, bus.o_stall_cycles);
        end
        #1;
        rst = 1'b0;
        tick();
        idle();
    endtask

    task automatic test_random();
        ret_t q[$];
        int   cyc      = 0;
        bit   need_new = 1;
        bit   eh, ei, es, eb;
        do_reset();
        repeat (600) begin
            if (q.size() > 0 && q[0].t == cyc) begin
                set_wb(1, q[0].rd);
                void'(q.pop_front());
            end else begin
                set_wb(0, 0);
            end
            if (need_new)
                set_id($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 1),
                       $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
                       $urandom_range(0, 9) < 7, 0, $urandom_range(0, 9) == 0);
            else
                bus.i_flush = ($urandom_range(0, 9) == 0);
            #2;
            eh = m_hazard();
            es = eh && !bus.i_flush;
            ei = bus.i_id_valid && !eh && !bus.i_flush;
            eb = es || bus.i_flush;
            n_vec++;
            if ({bus.o_issue, bus.o_stall, bus.o_bubble} !== {ei, es, eb}) begin
                n_bad++;
                $display("FAIL rand_ctl cyc=%0d got %b want %b", cyc,
                         {bus.o_issue, bus.o_stall, bus.o_bubble}, {ei, es, eb});
            end
            n_vec++;
            if (bus.o_stall_cycles !== 32'(m_stalls) || bus.o_err !== m_err) begin
                n_bad++;
                $display("FAIL rand_state cyc=%0d cnt=%0d err=%b want cnt=%0d err=%b", cyc,
                         bus.o_stall_cycles, bus.o_err, m_stalls, m_err);
            end
            if (ei && bus.i_dst_wr && bus.i_dst != 0) q.push_back('{cyc + 3, int'(bus.i_dst)});
            need_new = !es;
            tick();
            cyc++;
        end
        idle();
    endtask
`else
    task automatic test_forwarding();
        do_reset();
        set_id(1, 1, 1, 0, 0, 4, 1, 1, 0);
        tick();
        for (int c = 0; c < 2; c++) begin
            set_id(1, 4, 1, 2, 1, 6, 1, 0, 0);
            #2;
            n_vec++;
            if ({bus.o_issue, bus.o_stall} !== ((c == 0) ? 2'b01 : 2'b10)) begin
                n_bad++;
                $display("FAIL fwd_load_use c=%0d got %b", c, {bus.o_issue, bus.o_stall});
            end
            @(posedge clk);
            #1;
        end
        set_id(1, 1, 1, 0, 0, 4, 1, 0, 0);
        @(posedge clk);
        #1;
        set_id(1, 4, 1, 4, 1, 7, 1, 0, 0);
        set_wb(1, 9);
        #2;
        n_vec++;
        if ({bus.o_issue, bus.o_stall} !== 2'b10) begin
            n_bad++;
            $display("FAIL fwd_alu_use got %b want 10", {bus.o_issue, bus.o_stall});
        end
        @(posedge clk);
        #1;
        idle();
        #2;
        n_vec++;
        if (bus.o_err !== 1'b0 || bus.o_stall_cycles !== 32'd1) begin
            n_bad++;
            $display("FAIL fwd_state err=%b cnt=%0d want 0 1", bus.o_err, bus.o_stall_cycles);
        end
    endtask
`endif

    initial begin
        idle();
        test_reset();
`ifndef FORWARDING_EN
        test_dependent();
        test_two_writers();
        test_counter_max();
        test_same_cycle();
        test_flush();
        test_err_and_reset();
        test_random();
`else
        test_forwarding();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
